// File: rtl/ct_spsram_arb_ctrl.sv
// rtl/ct_spsram_arb_ctrl.sv - round-robin read/write port arbiter for a 512x44 single-port SRAM; init sweep under CT_SPSRAM_ARB_INIT_EN
module ct_spsram_arb_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 44,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  wr_req_vld,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [DATA_WIDTH-1:0] wr_req_bmask,
  output logic                  wr_req_rdy,
  input  logic                  rd_req_vld,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_rdy,
  output logic                  rd_resp_vld,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic                  sram_CEN,
  output logic                  sram_GWEN,
  output logic [DATA_WIDTH-1:0] sram_WEN,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state, next_state;
  logic   rr_last_wr;   // 1 = last grant went to the writer, so a read wins the next tie
  logic   gnt_rd, gnt_wr;
  logic   init_kick;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
  logic [ADDR_WIDTH-1:0] init_cnt;
  assign init_kick = init_req;
`else
  localparam state_t RESET_STATE = ST_RUN;
  logic unused_init_req;
  assign unused_init_req = init_req;
  assign init_kick = 1'b0;
`endif

  assign wr_req_rdy   = gnt_wr;
  assign rd_req_rdy   = gnt_rd;
  assign rd_resp_data = sram_Q;

  // State, arbitration history, init_done and read-response valid registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RESET_STATE;
      init_done   <= 1'b0;
      rd_resp_vld <= 1'b0;
      rr_last_wr  <= 1'b1;
    end else begin
      state       <= next_state;
      init_done   <= (next_state == ST_RUN);
      rd_resp_vld <= gnt_rd;
      if (gnt_rd || gnt_wr) rr_last_wr <= gnt_wr;
    end
  end

`ifdef CT_SPSRAM_ARB_INIT_EN
  // Sweep address: advances every INIT cycle, snaps back to 0 on init_req or outside INIT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) init_cnt <= '0;
    else if (state == ST_INIT && !init_kick) init_cnt <= init_cnt + 1'b1;
    else init_cnt <= '0;
  end
`endif

  // Next state, grant decision and SRAM pin drive
  always_comb begin
    next_state = state;
    gnt_rd     = 1'b0;
    gnt_wr     = 1'b0;
    sram_CEN   = 1'b1;
    sram_GWEN  = 1'b1;
    sram_WEN   = '1;
    sram_A     = '0;
    sram_D     = '0;
    case (state)
      ST_INIT: begin
`ifdef CT_SPSRAM_ARB_INIT_EN
        sram_CEN  = 1'b0;
        sram_GWEN = 1'b0;
        sram_WEN  = '0;
        sram_A    = init_cnt;
        sram_D    = INIT_VAL;
        if (init_kick) next_state = ST_INIT;
        else if (&init_cnt) next_state = ST_RUN;
`else
        next_state = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (init_kick) begin
          next_state = ST_INIT;
        end else if (!RST) begin
          gnt_rd = rd_req_vld && (!wr_req_vld || rr_last_wr);
          gnt_wr = wr_req_vld && (!rd_req_vld || !rr_last_wr);
        end
        if (gnt_wr) begin
          sram_CEN  = 1'b0;
          sram_GWEN = 1'b0;
          sram_WEN  = ~wr_req_bmask;
          sram_A    = wr_req_addr;
          sram_D    = wr_req_data;
        end else if (gnt_rd) begin
          sram_CEN  = 1'b0;
          sram_A    = rd_req_addr;
        end
      end
      default: next_state = RESET_STATE;
    endcase
    // Port stays idle while reset is held, whatever the state says
    if (RST) sram_CEN = 1'b1;
  end

endmodule
